// File: rtl/memory_bus_controller.sv
// CPU-side memory bus controller: on-chip RAM plus memory-mapped GPIO and a
// 16-bit match timer, with registered read data (one-cycle latency).
module memory_bus_controller #(
    parameter int                   WORD_SIZE     = 16,
    parameter int                   RAM_ADDR_SIZE = 10,
    parameter logic [WORD_SIZE-1:0] IO_BASE       = 16'hFF00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] memory_addr,
    input  logic [WORD_SIZE-1:0] memory_out,
    input  logic                 memory_write,
    output logic [WORD_SIZE-1:0] memory_in,
    input  logic [WORD_SIZE-1:0] gpio_in,
    output logic [WORD_SIZE-1:0] gpio_out,
    output logic                 timer_irq
);
    localparam int         RAM_DEPTH    = 2 ** RAM_ADDR_SIZE;
    localparam logic [2:0] OFS_GPIO_OUT = 3'd0;
    localparam logic [2:0] OFS_GPIO_IN  = 3'd1;
    localparam logic [2:0] OFS_COUNT    = 3'd2;
    localparam logic [2:0] OFS_COMPARE  = 3'd3;
    localparam logic [2:0] OFS_CTRL     = 3'd4;

    logic [WORD_SIZE-1:0] ram_r [RAM_DEPTH];
    logic [WORD_SIZE-1:0] gpio_meta_r;
    logic [WORD_SIZE-1:0] gpio_sync_r;
    logic [15:0]          count_r;
    logic [15:0]          compare_r;
    logic                 en_r;
    logic                 auto_reload_r;
    logic                 irq_en_r;
    logic                 match_r;

    logic                 is_ram_s;
    logic                 is_io_s;
    logic [2:0]           io_ofs_s;
    logic                 wr_ram_s;
    logic                 wr_gpio_s;
    logic                 wr_count_s;
    logic                 wr_compare_s;
    logic                 wr_ctrl_s;
    logic                 hit_s;
    logic [15:0]          count_next_s;
    logic                 match_next_s;
    logic [15:0]          ctrl_rd_s;
    logic [WORD_SIZE-1:0] rd_data_s;

    // Address decode and per-register write strobes.
    always_comb begin
        is_ram_s     = (memory_addr[WORD_SIZE-1:RAM_ADDR_SIZE] == {(WORD_SIZE-RAM_ADDR_SIZE){1'b0}});
        is_io_s      = (memory_addr[WORD_SIZE-1:3] == IO_BASE[WORD_SIZE-1:3]);
        io_ofs_s     = memory_addr[2:0];
        wr_ram_s     = memory_write & is_ram_s;
        wr_gpio_s    = memory_write & is_io_s & (io_ofs_s == OFS_GPIO_OUT);
        wr_count_s   = memory_write & is_io_s & (io_ofs_s == OFS_COUNT);
        wr_compare_s = memory_write & is_io_s & (io_ofs_s == OFS_COMPARE);
        wr_ctrl_s    = memory_write & is_io_s & (io_ofs_s == OFS_CTRL);
    end

    // Timer next state: CPU COUNT write beats reload/increment; a new match beats a clear.
    always_comb begin
        hit_s = en_r & (count_r == compare_r);
        if (wr_count_s) begin
            count_next_s = memory_out[15:0];
        end else if (hit_s && auto_reload_r) begin
            count_next_s = 16'h0000;
        end else if (en_r) begin
            count_next_s = count_r + 16'h0001;
        end else begin
            count_next_s = count_r;
        end
        if (hit_s) begin
            match_next_s = 1'b1;
        end else if (wr_ctrl_s && memory_out[15]) begin
            match_next_s = 1'b0;
        end else begin
            match_next_s = match_r;
        end
    end

    // Read mux; sampled into memory_in before any same-cycle write lands.
    always_comb begin
        ctrl_rd_s = {match_r, 12'h000, irq_en_r, auto_reload_r, en_r};
        rd_data_s = {WORD_SIZE{1'b0}};
        if (is_ram_s) begin
            rd_data_s = ram_r[memory_addr[RAM_ADDR_SIZE-1:0]];
        end else if (is_io_s) begin
            case (io_ofs_s)
                OFS_GPIO_OUT: rd_data_s = gpio_out;
                OFS_GPIO_IN:  rd_data_s = gpio_sync_r;
                OFS_COUNT:    rd_data_s = WORD_SIZE'(count_r);
                OFS_COMPARE:  rd_data_s = WORD_SIZE'(compare_r);
                OFS_CTRL:     rd_data_s = WORD_SIZE'(ctrl_rd_s);
                default:      rd_data_s = {WORD_SIZE{1'b0}};
            endcase
        end else begin
            rd_data_s = {WORD_SIZE{1'b0}};
        end
    end

    // RAM array: contents survive reset, but no write is accepted while reset is held.
    always_ff @(posedge clk) begin
        if (wr_ram_s && !rst) begin
            ram_r[memory_addr[RAM_ADDR_SIZE-1:0]] <= memory_out;
        end
    end

    // Bus read register, GPIO, synchronizer and timer state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memory_in     <= {WORD_SIZE{1'b0}};
            gpio_out      <= {WORD_SIZE{1'b0}};
            gpio_meta_r   <= {WORD_SIZE{1'b0}};
            gpio_sync_r   <= {WORD_SIZE{1'b0}};
            count_r       <= 16'h0000;
            compare_r     <= 16'hFFFF;
            en_r          <= 1'b0;
            auto_reload_r <= 1'b0;
            irq_en_r      <= 1'b0;
            match_r       <= 1'b0;
            timer_irq     <= 1'b0;
        end else begin
            memory_in   <= rd_data_s;
            gpio_meta_r <= gpio_in;
            gpio_sync_r <= gpio_meta_r;
            if (wr_gpio_s) begin
                gpio_out <= memory_out;
            end
            if (wr_compare_s) begin
                compare_r <= memory_out[15:0];
            end
            if (wr_ctrl_s) begin
                en_r          <= memory_out[0];
                auto_reload_r <= memory_out[1];
                irq_en_r      <= memory_out[2];
            end
            count_r   <= count_next_s;
            match_r   <= match_next_s;
            timer_irq <= match_r & irq_en_r;
        end
    end

endmodule

// File: tb/tb_memory_bus_controller.sv
// Randomized scoreboard bench for memory_bus_controller against a behavioural
// model of the RAM, GPIO and match-timer rules.
module tb_memory_bus_controller;
    localparam logic [15:0] IOB = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] memory_addr = 16'h0000;
    logic [15:0] memory_out = 16'h0000;
    logic        memory_write = 1'b0;
    logic [15:0] memory_in;
    logic [15:0] gpio_in = 16'h0000;
    logic [15:0] gpio_out;
    logic        timer_irq;

    int total = 0;
    int bad = 0;
    int cycle_cnt = 0;

    typedef struct {
        int          cyc;
        bit          chk_mem;
        logic [15:0] mem;
        logic [15:0] gpo;
        logic        irq;
    } exp_t;
    exp_t q[$];

    logic [15:0] m_ram [int];
    int m_count, m_compare, m_gpo, m_g1, m_g2;
    bit m_en, m_ar, m_ie, m_match, m_irq;

    memory_bus_controller #(.WORD_SIZE(16), .RAM_ADDR_SIZE(10), .IO_BASE(16'hFF00)) dut (
        .clk(clk), .rst(rst), .memory_addr(memory_addr), .memory_out(memory_out),
        .memory_write(memory_write), .memory_in(memory_in), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops every expectation whose edge has passed and compares outputs.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cycle_cnt) begin
            e = q.pop_front();
            if (e.chk_mem) check("memory_in", memory_in, e.mem);
            check("gpio_out", gpio_out, e.gpo);
            check("timer_irq", {15'd0, timer_irq}, {15'd0, e.irq});
        end
    end

    function automatic void model_reset();
        m_count = 0; m_compare = 65535; m_gpo = 0; m_g1 = 0; m_g2 = 0;
        m_en = 1'b0; m_ar = 1'b0; m_ie = 1'b0; m_match = 1'b0; m_irq = 1'b0;
    endfunction

    function automatic void model_read(input int a, output bit ok, output logic [15:0] v);
        ok = 1'b1;
        v = 16'h0000;
        if (a < 1024) begin
            if (m_ram.exists(a)) v = m_ram[a];
            else ok = 1'b0;
        end else if (a >= int'(IOB) && a <= int'(IOB) + 7) begin
            case (a - int'(IOB))
                0: v = m_gpo[15:0];
                1: v = m_g2[15:0];
                2: v = m_count[15:0];
                3: v = m_compare[15:0];
                4: v = {m_match, 12'h000, m_ie, m_ar, m_en};
                default: v = 16'h0000;
            endcase
        end
    endfunction

    // One bus cycle: drive, predict the post-edge outputs, advance the model, wait the edge.
    task automatic bus(input int a, input int d, input bit we);
        exp_t e;
        bit ok, hit, match_n, irq_n;
        logic [15:0] v;
        int count_n;
        memory_addr = a[15:0];
        memory_out = d[15:0];
        memory_write = we;
        model_read(a, ok, v);
        hit = m_en && (m_count == m_compare);
        irq_n = m_match && m_ie;
        match_n = hit ? 1'b1 : ((we && a == int'(IOB) + 4 && d[15]) ? 1'b0 : m_match);
        if (m_en) count_n = (hit && m_ar) ? 0 : (m_count + 1) % 65536;
        else count_n = m_count;
        if (we) begin
            if (a < 1024) m_ram[a] = d[15:0];
            else if (a == int'(IOB)) m_gpo = d & 65535;
            else if (a == int'(IOB) + 2) count_n = d & 65535;
            else if (a == int'(IOB) + 3) m_compare = d & 65535;
            else if (a == int'(IOB) + 4) begin
                m_en = d[0]; m_ar = d[1]; m_ie = d[2];
            end
        end
        m_count = count_n;
        m_match = match_n;
        m_irq = irq_n;
        m_g2 = m_g1;
        m_g1 = int'(gpio_in);
        e.cyc = cycle_cnt + 1;
        e.chk_mem = ok;
        e.mem = v;
        e.gpo = m_gpo[15:0];
        e.irq = m_irq;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset between edges; any access in flight is abandoned.
    task automatic do_reset();
        memory_write = 1'b0;
        #2;
        q.delete();
        rst = 1'b1;
        #1;
        check("rst memory_in", memory_in, 16'h0000);
        check("rst gpio_out", gpio_out, 16'h0000);
        check("rst timer_irq", {15'd0, timer_irq}, 16'h0000);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int sel, a, d;
        bit we;
        #1 rst = 1'b1;
        #2;
        check("init memory_in", memory_in, 16'h0000);
        check("init gpio_out", gpio_out, 16'h0000);
        check("init timer_irq", {15'd0, timer_irq}, 16'h0000);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // RAM write then held read
        bus(5, 16'h1234, 1'b1);
        bus(5, 0, 1'b0);
        bus(5, 0, 1'b0);
        check("ram read", memory_in, 16'h1234);

        // GPIO out/in and unmapped read
        bus(IOB, 16'hA5A5, 1'b1);
        check("gpio_out", gpio_out, 16'hA5A5);
        gpio_in = 16'h00F0;
        for (int i = 0; i < 3; i++) bus(IOB + 1, 0, 1'b0);
        check("gpio_in read", memory_in, 16'h00F0);
        bus(16'h8000, 16'h7777, 1'b1);
        bus(16'h8000, 0, 1'b0);
        check("unmapped read", memory_in, 16'h0000);

        // Auto-reload match and IRQ
        bus(IOB + 3, 5, 1'b1);
        bus(IOB + 2, 0, 1'b1);
        bus(IOB + 4, 16'h0007, 1'b1);
        for (int i = 0; i < 7; i++) bus(IOB + 2, 0, 1'b0);
        check("irq after match", {15'd0, timer_irq}, 16'h0001);
        bus(IOB + 4, 16'h8007, 1'b1);
        bus(IOB + 4, 0, 1'b0);
        check("irq after clear", {15'd0, timer_irq}, 16'h0000);

        // Wrap without reload
        bus(IOB + 4, 16'h0000, 1'b1);
        bus(IOB + 4, 16'h8000, 1'b1);
        bus(IOB + 3, 3, 1'b1);
        bus(IOB + 2, 16'hFFFE, 1'b1);
        bus(IOB + 4, 16'h0001, 1'b1);
        for (int i = 0; i < 9; i++) bus(IOB + 2, 0, 1'b0);

        // COUNT write beats increment; match beats clear
        bus(IOB + 2, 16'h0100, 1'b1);
        bus(IOB + 2, 0, 1'b0);
        check("count write wins", memory_in, 16'h0100);
        bus(IOB + 4, 16'h0000, 1'b1);
        bus(IOB + 4, 16'h8000, 1'b1);
        bus(IOB + 3, 10, 1'b1);
        bus(IOB + 2, 8, 1'b1);
        bus(IOB + 4, 16'h0001, 1'b1);
        bus(IOB + 2, 0, 1'b0);
        bus(IOB + 2, 0, 1'b0);
        bus(IOB + 4, 16'h8001, 1'b1);
        bus(IOB + 4, 0, 1'b0);
        check("match beats clear", memory_in, 16'h8001);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: a = $urandom_range(0, 15);
                4: a = (i % 2 == 1) ? 1023 : 1024;
                5, 6, 7: a = int'(IOB) + $urandom_range(0, 7);
                8: a = ($urandom_range(0, 1) == 1) ? 32'hFEFF : 32'hFF08;
                default: a = 32'h8000 + $urandom_range(0, 255);
            endcase
            d = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 65535) : $urandom_range(0, 24);
            if (a == int'(IOB) + 4 && $urandom_range(0, 3) != 0) d = d | 1;
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) gpio_in = 16'($urandom);
            bus(a, d, we);
        end

        // Reset while timer runs and a read is pending; RAM persists
        bus(300, 16'hC0DE, 1'b1);
        bus(IOB, 16'h5A5A, 1'b1);
        bus(IOB + 4, 16'h0007, 1'b1);
        bus(IOB + 2, 0, 1'b0);
        do_reset();
        bus(IOB + 3, 0, 1'b0);
        bus(IOB + 3, 0, 1'b0);
        check("compare after rst", memory_in, 16'hFFFF);
        bus(300, 0, 1'b0);
        bus(300, 0, 1'b0);
        check("ram after rst", memory_in, 16'hC0DE);
        bus(IOB + 2, 0, 1'b0);
        bus(IOB + 2, 0, 1'b0);
        check("count after rst", memory_in, 16'h0000);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
